// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder.
// The master side issues start/Value/Mode and the slave side returns busy/done/ok/Imm24.
interface imm_encoder_if;
    logic        start;
    logic [31:0] Value;
    logic [1:0]  Mode;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] Imm24;

    modport master (
        output start, Value, Mode,
        input  busy, done, ok, Imm24
    );

    modport slave (
        input  start, Value, Mode,
        output busy, done, ok, Imm24
    );
endinterface

// File: rtl/imm_encoder.sv
// Encodes a 32-bit constant or byte offset into the low 24 bits of an instruction word.
// Data-processing immediates are found by a serial search over the 16 even rotations,
// one candidate per cycle. Load/store offsets, branch offsets and the reserved mode
// all resolve on the first search cycle.
module imm_encoder (
    input  logic       clk,
    input  logic       rst_n,
    imm_encoder_if.slave bus
);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t      state;
    logic [3:0]  rc;
    logic [31:0] val_q;
    logic [1:0]  mode_q;
    logic        busy_q;
    logic        done_q;
    logic        ok_q;
    logic [23:0] imm_q;

    logic [5:0]  sh;
    logic [31:0] rot;
    logic        fin;
    logic        ok_n;
    logic [23:0] imm_n;

    // Evaluate the current candidate; non-rotation modes finish immediately.
    // At rc=0 the right shift is by 32 and yields zero, so rot equals val_q.
    always_comb begin
        sh    = {1'b0, rc, 1'b0};
        rot   = (val_q << sh) | (val_q >> (6'd32 - sh));
        fin   = 1'b1;
        ok_n  = 1'b0;
        imm_n = '0;
        case (mode_q)
            2'b00: begin
                ok_n = (rot[31:8] == 24'd0);
                fin  = ok_n || (rc == 4'd15);
                if (ok_n) imm_n = {12'b0, rc, rot[7:0]};
            end
            2'b01: begin
                ok_n = (val_q[31:12] == 20'd0);
                if (ok_n) imm_n = {12'b0, val_q[11:0]};
            end
            2'b10: begin
                ok_n = (val_q[1:0] == 2'b00) && (val_q[31:26] == {6{val_q[25]}});
                if (ok_n) imm_n = val_q[25:2];
            end
            default: begin
                ok_n  = 1'b0;
                imm_n = '0;
            end
        endcase
    end

    // Request sequencing: capture in IDLE, step the rotation counter in SEARCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rc     <= '0;
            val_q  <= '0;
            mode_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            imm_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        val_q  <= bus.Value;
                        mode_q <= bus.Mode;
                        rc     <= '0;
                        busy_q <= 1'b1;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (fin) begin
                        done_q <= 1'b1;
                        ok_q   <= ok_n;
                        imm_q  <= imm_n;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rc <= rc + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ok    = ok_q;
    assign bus.Imm24 = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized requests
// checked against an arithmetic reference model of the encoding rules.
module tb_imm_encoder;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the encoding should be, how many edges after acceptance done appears.
    function automatic void model(input logic [31:0] v, input logic [1:0] m,
                                  output logic e_ok, output logic [23:0] e_imm, output int e_lat);
        longint sv;
        logic [31:0] r32;
        e_ok  = 1'b0;
        e_imm = 24'd0;
        e_lat = 1;
        case (m)
            2'd0: begin
                e_lat = 16;
                for (int r = 0; r < 16; r++) begin
                    if (!e_ok) begin
                        // imm8 such that imm8 ror 2r == v is v rol 2r
                        if (r == 0) r32 = v;
                        else r32 = (v << (2 * r)) | (v >> (32 - 2 * r));
                        if (r32 < 32'd256) begin
                            e_ok  = 1'b1;
                            e_imm = 24'(r * 256 + int'(r32));
                            e_lat = r + 1;
                        end
                    end
                end
            end
            2'd1: begin
                e_ok  = (v < 32'd4096);
                e_imm = e_ok ? 24'(v) : 24'd0;
            end
            2'd2: begin
                sv   = longint'(signed'(v));
                e_ok = (v % 4 == 0) && (sv >= -(64'sd1 <<< 25)) && (sv < (64'sd1 <<< 25));
                e_imm = e_ok ? 24'(sv / 4) : 24'd0;
            end
            default: begin
                e_ok  = 1'b0;
                e_imm = 24'd0;
            end
        endcase
    endfunction

    // Issue one request and observe: latency in edges after acceptance, result,
    // number of cycles busy was seen high before done, and number of done cycles.
    task automatic run_req(input logic [31:0] v, input logic [1:0] m,
                           output int lat, output logic r_ok, output logic [23:0] r_imm,
                           output int busy_cnt, output int done_cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Value = v;
        bus.Mode  = m;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        r_ok = 1'b0;
        r_imm = 24'd0;
        done_cnt = 0;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                r_ok = bus.ok;
                r_imm = bus.Imm24;
                done_cnt++;
                break;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
        @(negedge clk);
        if (bus.done) done_cnt++;
    endtask

    task automatic test_reset;
        int lat;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.Value = 32'd0;
        bus.Mode = 2'd0;
        #12;
        total++;
        if ({bus.busy, bus.done, bus.ok, bus.Imm24} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b ok=%b imm=%h want all 0",
                     bus.busy, bus.done, bus.ok, bus.Imm24);
        end
        // start already present when reset releases: accepted at the first edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.Value = 32'h000000FF;
        bus.Mode = 2'd0;
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL first_start_busy got %b want 1", bus.busy);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = i; break; end
        end
        total++;
        if (lat !== 1 || bus.ok !== 1'b1 || bus.Imm24 !== 24'h0000FF) begin
            bad++;
            $display("FAIL first_start got lat=%0d ok=%b imm=%h want lat=1 ok=1 imm=0000ff",
                     lat, bus.ok, bus.Imm24);
        end
    endtask

    task automatic test_mode00_rotation;
        logic [31:0] vals [3] = '{32'h000000FF, 32'hF000000F, 32'hFF000000};
        logic [23:0] imms [3] = '{24'h0000FF, 24'h0002FF, 24'h0004FF};
        int          lats [3] = '{1, 3, 5};
        int lat, bc, dc;
        logic ok;
        logic [23:0] imm;
        for (int i = 0; i < 3; i++) begin
            run_req(vals[i], 2'd0, lat, ok, imm, bc, dc);
            total++;
            if (ok !== 1'b1 || imm !== imms[i] || lat != lats[i] || dc != 1) begin
                bad++;
                $display("FAIL mode00_%h got ok=%b imm=%h lat=%0d dones=%0d want ok=1 imm=%h lat=%0d dones=1",
                         vals[i], ok, imm, lat, dc, imms[i], lats[i]);
            end
        end
    endtask

    task automatic test_mode00_unencodable;
        int lat, bc, dc;
        logic ok;
        logic [23:0] imm;
        run_req(32'h00000102, 2'd0, lat, ok, imm, bc, dc);
        total++;
        if (ok !== 1'b0 || imm !== 24'd0 || lat != 16 || dc != 1) begin
            bad++;
            $display("FAIL mode00_unenc got ok=%b imm=%h lat=%0d dones=%0d want ok=0 imm=0 lat=16 dones=1",
                     ok, imm, lat, dc);
        end
        total++;
        if (bc != 16) begin
            bad++;
            $display("FAIL mode00_unenc_busy got %0d cycles want 16", bc);
        end
    endtask

    task automatic test_mode10;
        logic [31:0] vals [3] = '{32'hFFFFFFF8, 32'h00000006, 32'h02000000};
        logic        oks  [3] = '{1'b1, 1'b0, 1'b0};
        logic [23:0] imms [3] = '{24'hFFFFFE, 24'd0, 24'd0};
        int lat, bc, dc;
        logic ok;
        logic [23:0] imm;
        for (int i = 0; i < 3; i++) begin
            run_req(vals[i], 2'd2, lat, ok, imm, bc, dc);
            total++;
            if (ok !== oks[i] || imm !== imms[i] || lat != 1) begin
                bad++;
                $display("FAIL mode10_%h got ok=%b imm=%h lat=%0d want ok=%b imm=%h lat=1",
                         vals[i], ok, imm, lat, oks[i], imms[i]);
            end
        end
    endtask

    task automatic test_mode01_11;
        int lat, bc, dc;
        logic ok;
        logic [23:0] imm;
        run_req(32'h00000FFF, 2'd1, lat, ok, imm, bc, dc);
        total++;
        if (ok !== 1'b1 || imm !== 24'h000FFF || lat != 1) begin
            bad++;
            $display("FAIL mode01_fff got ok=%b imm=%h lat=%0d want ok=1 imm=000fff lat=1", ok, imm, lat);
        end
        run_req(32'h00001000, 2'd1, lat, ok, imm, bc, dc);
        total++;
        if (ok !== 1'b0 || imm !== 24'd0 || lat != 1) begin
            bad++;
            $display("FAIL mode01_1000 got ok=%b imm=%h lat=%0d want ok=0 imm=0 lat=1", ok, imm, lat);
        end
        // prime a nonzero result so the reserved mode has to clear it
        run_req(32'h000000FF, 2'd0, lat, ok, imm, bc, dc);
        run_req(32'h000000FF, 2'd3, lat, ok, imm, bc, dc);
        total++;
        if (ok !== 1'b0 || imm !== 24'd0 || lat != 1 || dc != 1) begin
            bad++;
            $display("FAIL mode11 got ok=%b imm=%h lat=%0d dones=%0d want ok=0 imm=0 lat=1 dones=1",
                     ok, imm, lat, dc);
        end
    endtask

    task automatic test_start_during_search;
        int lat, dc;
        logic ok;
        logic [23:0] imm;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Value = 32'hFF000000;
        bus.Mode = 2'd0;
        @(negedge clk);           // edge E passed
        bus.start = 1'b0;
        lat = -1;
        dc = 0;
        ok = 1'b0;
        imm = 24'd0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;  // sampled at edge E+2 while busy
                bus.Value = 32'h000000FF;
                bus.Mode = 2'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                dc++;
                if (lat < 0) begin
                    lat = i;
                    ok = bus.ok;
                    imm = bus.Imm24;
                end
            end
        end
        total++;
        if (ok !== 1'b1 || imm !== 24'h0004FF || lat != 5 || dc != 1) begin
            bad++;
            $display("FAIL start_while_busy got ok=%b imm=%h lat=%0d dones=%0d want ok=1 imm=0004ff lat=5 dones=1",
                     ok, imm, lat, dc);
        end
    endtask

    task automatic test_reset_mid_search;
        int lat, bc, dc;
        logic ok;
        logic [23:0] imm;
        run_req(32'hF000000F, 2'd0, lat, ok, imm, bc, dc);  // leaves ok=1, Imm24 nonzero
        @(negedge clk);
        bus.start = 1'b1;
        bus.Value = 32'h00000102;
        bus.Mode = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.ok, bus.Imm24} !== 27'd0) begin
            bad++;
            $display("FAIL reset_mid_search got busy=%b done=%b ok=%b imm=%h want all 0",
                     bus.busy, bus.done, bus.ok, bus.Imm24);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        total++;
        if (dc != 0) begin
            bad++;
            $display("FAIL reset_abandon got %0d active cycles want 0", dc);
        end
        run_req(32'h000000FF, 2'd0, lat, ok, imm, bc, dc);
        total++;
        if (ok !== 1'b1 || imm !== 24'h0000FF || lat != 1 || dc != 1) begin
            bad++;
            $display("FAIL after_reset got ok=%b imm=%h lat=%0d dones=%0d want ok=1 imm=0000ff lat=1 dones=1",
                     ok, imm, lat, dc);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic ok;
        logic [23:0] imm;
        int e_lat;
        logic e_ok;
        logic [23:0] e_imm;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Value = 32'hF000000F;
        bus.Mode = 2'd0;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = i; break; end
        end
        // second request presented during the done cycle
        bus.start = 1'b1;
        bus.Value = 32'hFFFFFFF8;
        bus.Mode = 2'd2;
        @(negedge clk);
        bus.start = 1'b0;
        model(32'hFFFFFFF8, 2'd2, e_ok, e_imm, e_lat);
        lat = -1;
        ok = 1'b0;
        imm = 24'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = i; ok = bus.ok; imm = bus.Imm24; break; end
        end
        total++;
        if (ok !== e_ok || imm !== e_imm || lat != e_lat) begin
            bad++;
            $display("FAIL back_to_back got ok=%b imm=%h lat=%0d want ok=%b imm=%h lat=%0d",
                     ok, imm, lat, e_ok, e_imm, e_lat);
        end
    endtask

    task automatic test_random;
        int lat, bc, dc, e_lat;
        logic ok, e_ok;
        logic [23:0] imm, e_imm;
        logic [31:0] v, x;
        logic [1:0] m;
        int s;
        for (int n = 0; n < 60; n++) begin
            m = 2'($urandom_range(0, 3));
            v = $urandom;
            if (m == 2'd0 && $urandom_range(0, 2) != 0) begin
                v = $urandom_range(0, 255);
                s = 2 * $urandom_range(0, 15);
                if (s != 0) v = (v >> s) | (v << (32 - s));
            end else if (m == 2'd1 && $urandom_range(0, 1) != 0) begin
                v = $urandom_range(0, 8191);
            end else if (m == 2'd2 && $urandom_range(0, 1) != 0) begin
                v = 32'(signed'($urandom_range(0, 1 << 26)) - (1 << 25));
                if ($urandom_range(0, 3) != 0) v = v & ~32'd3;
            end
            model(v, m, e_ok, e_imm, e_lat);
            run_req(v, m, lat, ok, imm, bc, dc);
            total++;
            if (ok !== e_ok || imm !== e_imm || lat != e_lat || dc != 1 || bc != e_lat) begin
                bad++;
                $display("FAIL random_m%0d_%h got ok=%b imm=%h lat=%0d busy=%0d dones=%0d want ok=%b imm=%h lat=%0d dones=1",
                         m, v, ok, imm, lat, bc, dc, e_ok, e_imm, e_lat);
            end
            if (ok === 1'b1 && (m == 2'd0 || m == 2'd2)) begin
                if (m == 2'd0) begin
                    x = {24'd0, imm[7:0]};
                    s = 2 * int'(imm[11:8]);
                    if (s != 0) x = (x >> s) | (x << (32 - s));
                end else begin
                    x = {{8{imm[23]}}, imm} << 2;
                end
                total++;
                if (x !== v) begin
                    bad++;
                    $display("FAIL roundtrip_m%0d got %h want %h", m, x, v);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_mode00_rotation;
        test_mode00_unencodable;
        test_mode10;
        test_mode01_11;
        test_start_during_search;
        test_reset_mid_search;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
